// File: rtl/jellyvl_etherneco_rx_deframer.sv
// EtherNeco ring port receive deframer.
// Strips preamble/SFD (and optionally the FCS), checks CRC32, reports per-frame status.
module jellyvl_etherneco_rx_deframer #(
  parameter int PREAMBLE_MIN = 1,
  parameter bit STRIP_FCS    = 1'b1,
  parameter int LEN_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           s_gmii_rxd,
  input  logic                 s_gmii_rx_dv,
  input  logic                 s_gmii_rx_er,
  output logic                 m_rx_first,
  output logic                 m_rx_last,
  output logic [7:0]           m_rx_data,
  output logic                 m_rx_valid,
  output logic                 m_frame_end,
  output logic                 m_frame_crc_error,
  output logic                 m_frame_phy_error,
  output logic                 m_frame_short,
  output logic [LEN_WIDTH-1:0] m_frame_length
);

  localparam int          DELAY       = STRIP_FCS ? 5 : 1;
  localparam logic [2:0]  PRE_MIN     = 3'(PREAMBLE_MIN);
  localparam logic [2:0]  DELAY_N     = 3'(DELAY);
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    PREAMBLE,
    BODY
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [2:0]           pre_cnt;
  logic [7:0]           dline [DELAY];
  logic [2:0]           held;
  logic                 ovf;
  logic                 phy_err;
  logic [31:0]          crc;
  logic [LEN_WIDTH-1:0] len_cnt;

  logic                 full;
  logic                 body_beat;
  logic                 end_beat;
  logic                 frame_end;
  logic [LEN_WIDTH-1:0] len_inc;

  function automatic logic [31:0] crc_step(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  always_comb begin
    state_next = state;
    unique case (state)
      WAIT_IDLE: begin
        if (!s_gmii_rx_dv) state_next = IDLE;
      end
      IDLE: begin
        if (s_gmii_rx_dv) begin
          state_next = (s_gmii_rxd == 8'h55) ? PREAMBLE : WAIT_IDLE;
        end
      end
      PREAMBLE: begin
        if (!s_gmii_rx_dv) begin
          state_next = IDLE;
        end else if (s_gmii_rx_er) begin
          state_next = WAIT_IDLE;
        end else if (s_gmii_rxd == 8'h55) begin
          state_next = PREAMBLE;
        end else if (s_gmii_rxd == 8'hD5 && pre_cnt >= PRE_MIN) begin
          state_next = BODY;
        end else begin
          state_next = WAIT_IDLE;
        end
      end
      BODY: begin
        if (!s_gmii_rx_dv) state_next = IDLE;
      end
      default: state_next = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= WAIT_IDLE;
    else        state <= state_next;
  end

  // With FCS stripping, an end beat exists only once the line has overflowed;
  // otherwise the held byte is itself the final payload byte.
  assign full      = (held == DELAY_N);
  assign body_beat = (state == BODY) && s_gmii_rx_dv && full;
  assign frame_end = (state == BODY) && !s_gmii_rx_dv;
  assign end_beat  = frame_end && (STRIP_FCS ? ovf : full);
  assign len_inc   = (&len_cnt) ? len_cnt : len_cnt + LEN_WIDTH'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt           <= 3'd0;
      held              <= 3'd0;
      ovf               <= 1'b0;
      phy_err           <= 1'b0;
      crc               <= 32'hFFFFFFFF;
      len_cnt           <= '0;
      for (int i = 0; i < DELAY; i++) dline[i] <= 8'd0;
      m_rx_first        <= 1'b0;
      m_rx_last         <= 1'b0;
      m_rx_data         <= 8'd0;
      m_rx_valid        <= 1'b0;
      m_frame_end       <= 1'b0;
      m_frame_crc_error <= 1'b0;
      m_frame_phy_error <= 1'b0;
      m_frame_short     <= 1'b0;
      m_frame_length    <= '0;
    end else begin
      m_rx_valid        <= body_beat | end_beat;
      m_rx_first        <= (body_beat | end_beat) & ~ovf;
      m_rx_last         <= end_beat;
      if (body_beat | end_beat) m_rx_data <= dline[DELAY-1];

      m_frame_end       <= frame_end;
      m_frame_crc_error <= frame_end && (crc != CRC_RESIDUE);
      m_frame_phy_error <= frame_end && phy_err;
      m_frame_short     <= frame_end && !end_beat;
      m_frame_length    <= !frame_end ? '0 :
                           end_beat   ? len_inc : len_cnt;

      if (state == IDLE) begin
        pre_cnt <= 3'd1;
      end else if (state == PREAMBLE && s_gmii_rxd == 8'h55 && pre_cnt != 3'd7) begin
        pre_cnt <= pre_cnt + 3'd1;
      end

      if (state == BODY && s_gmii_rx_dv) begin
        for (int i = DELAY - 1; i > 0; i--) dline[i] <= dline[i-1];
        dline[0] <= s_gmii_rxd;
        crc      <= crc_step(crc, s_gmii_rxd);
        phy_err  <= phy_err | s_gmii_rx_er;
        if (full) begin
          ovf     <= 1'b1;
          len_cnt <= len_inc;
        end else begin
          held <= held + 3'd1;
        end
      end

      if (frame_end) begin
        held    <= 3'd0;
        ovf     <= 1'b0;
        phy_err <= 1'b0;
        crc     <= 32'hFFFFFFFF;
        len_cnt <= '0;
        for (int i = 0; i < DELAY; i++) dline[i] <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_jellyvl_etherneco_rx_deframer.sv
// Scoreboard bench for the EtherNeco rx deframer.
// Two instances (FCS stripped / forwarded) share one randomized GMII stream.
module tb_jellyvl_etherneco_rx_deframer;

  localparam logic [31:0] POLY    = 32'hEDB88320;
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
  localparam int MIN0 = 3;
  localparam int MIN1 = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rxd;
  logic       dv;
  logic       er;

  logic        f0, l0, v0, fe0, ce0, pe0, sh0;
  logic [7:0]  d0;
  logic [15:0] len0;
  logic        f1, l1, v1, fe1, ce1, pe1, sh1;
  logic [7:0]  d1;
  logic [15:0] len1;

  logic [9:0]  bq0 [$];
  logic [9:0]  bq1 [$];
  logic [18:0] sq0 [$];
  logic [18:0] sq1 [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jellyvl_etherneco_rx_deframer #(
    .PREAMBLE_MIN(MIN0), .STRIP_FCS(1'b1), .LEN_WIDTH(16)
  ) u0 (
    .clk(clk), .reset(reset),
    .s_gmii_rxd(rxd), .s_gmii_rx_dv(dv), .s_gmii_rx_er(er),
    .m_rx_first(f0), .m_rx_last(l0), .m_rx_data(d0), .m_rx_valid(v0),
    .m_frame_end(fe0), .m_frame_crc_error(ce0), .m_frame_phy_error(pe0),
    .m_frame_short(sh0), .m_frame_length(len0)
  );

  jellyvl_etherneco_rx_deframer #(
    .PREAMBLE_MIN(MIN1), .STRIP_FCS(1'b0), .LEN_WIDTH(16)
  ) u1 (
    .clk(clk), .reset(reset),
    .s_gmii_rxd(rxd), .s_gmii_rx_dv(dv), .s_gmii_rx_er(er),
    .m_rx_first(f1), .m_rx_last(l1), .m_rx_data(d1), .m_rx_valid(v1),
    .m_frame_end(fe1), .m_frame_crc_error(ce1), .m_frame_phy_error(pe1),
    .m_frame_short(sh1), .m_frame_length(len1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Bit-serial LFSR form of the reflected CRC32, no final inversion.
  function automatic logic [31:0] crc_bytes(input logic [7:0] b [$]);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ b[i][j];
        c  = c >> 1;
        if (fb) c = c ^ POLY;
      end
    end
    return c;
  endfunction

  task automatic expect_frame(input int pre_n, input logic [7:0] body [$], input bit er_any);
    int   n;
    int   p;
    bit   strip;
    bit   crc_err;
    n       = body.size();
    crc_err = (crc_bytes(body) != RESIDUE);
    for (int s = 0; s < 2; s++) begin
      if (pre_n < (s == 0 ? MIN0 : MIN1)) continue;
      strip = (s == 0);
      p     = strip ? ((n >= 6) ? n - 4 : 0) : n;
      for (int i = 0; i < p; i++) begin
        if (s == 0) bq0.push_back({i == 0, i == p - 1, body[i]});
        else        bq1.push_back({i == 0, i == p - 1, body[i]});
      end
      if (s == 0) sq0.push_back({crc_err, er_any, p == 0, 16'(p)});
      else        sq1.push_back({crc_err, er_any, p == 0, 16'(p)});
    end
  endtask

  task automatic send(input bit v, input logic [7:0] d, input bit e);
    @(posedge clk);
    #1;
    dv  = v;
    rxd = d;
    er  = e;
  endtask

  task automatic frame(input int pre_n, input logic [7:0] body [$], input int er_idx);
    expect_frame(pre_n, body, er_idx >= 0 && er_idx < body.size());
    repeat (pre_n) send(1'b1, 8'h55, 1'b0);
    send(1'b1, 8'hD5, 1'b0);
    foreach (body[i]) send(1'b1, body[i], i == er_idx);
    send(1'b0, 8'h00, 1'b0);
  endtask

  function automatic logic [7:0] rand_bytes_q(input int n, inout logic [7:0] q [$]);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return 8'(n);
  endfunction

  logic [9:0]  eb0, eb1;
  logic [18:0] es0, es1;

  always @(negedge clk) begin
    if (reset) begin
      if (v0) begin
        if (bq0.size() == 0) chk("beat0_unexpected", {24'd0, d0}, 32'h100);
        else begin
          eb0 = bq0.pop_front();
          chk("beat0", {22'd0, f0, l0, d0}, {22'd0, eb0});
        end
      end
      if (fe0) begin
        if (sq0.size() == 0) chk("stat0_unexpected", {13'd0, ce0, pe0, sh0, len0}, 32'hFFFFFFFF);
        else begin
          es0 = sq0.pop_front();
          chk("stat0", {13'd0, ce0, pe0, sh0, len0}, {13'd0, es0});
        end
      end
      if (v1) begin
        if (bq1.size() == 0) chk("beat1_unexpected", {24'd0, d1}, 32'h100);
        else begin
          eb1 = bq1.pop_front();
          chk("beat1", {22'd0, f1, l1, d1}, {22'd0, eb1});
        end
      end
      if (fe1) begin
        if (sq1.size() == 0) chk("stat1_unexpected", {13'd0, ce1, pe1, sh1, len1}, 32'hFFFFFFFF);
        else begin
          es1 = sq1.pop_front();
          chk("stat1", {13'd0, ce1, pe1, sh1, len1}, {13'd0, es1});
        end
      end
    end
  end

  logic [7:0]  good [$];
  logic [7:0]  body [$];
  logic [31:0] fcs;
  logic [7:0]  nb;
  int          len;
  int          er_idx;

  initial begin
    reset = 1'b0;
    dv    = 1'b0;
    rxd   = 8'h00;
    er    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out0", {1'b0, f0, l0, v0, fe0, ce0, pe0, sh0, d0, len0}, 32'd0);
    chk("reset_out1", {1'b0, f1, l1, v1, fe1, ce1, pe1, sh1, d1, len1}, 32'd0);
    reset = 1'b1;
    repeat (3) send(1'b0, 8'h00, 1'b0);

    good = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
             8'h26, 8'h39, 8'hF4, 8'hCB};
    frame(7, good, -1);
    body = good;
    body[12] = 8'hCA;
    frame(7, body, -1);
    frame(7, '{8'h01, 8'h02, 8'h03}, -1);
    frame(7, good, 3);
    body = {};
    frame(7, body, -1);
    nb = rand_bytes_q(5, body);
    frame(7, body, -1);
    nb = rand_bytes_q(6, body);
    frame(7, body, -1);

    // Preamble corrupted by rx_er, then by a 0x54: nothing may come out.
    send(1'b1, 8'h55, 1'b0);
    send(1'b1, 8'h55, 1'b1);
    send(1'b1, 8'h55, 1'b0);
    send(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < 6; i++) send(1'b1, 8'h41 + 8'(i), 1'b0);
    send(1'b0, 8'h00, 1'b0);
    send(1'b1, 8'h55, 1'b0);
    send(1'b1, 8'h54, 1'b0);
    send(1'b1, 8'h55, 1'b0);
    send(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < 6; i++) send(1'b1, 8'h61 + 8'(i), 1'b0);
    send(1'b0, 8'h00, 1'b0);

    // Reset in mid frame, released while dv is still high on preamble-like bytes.
    repeat (7) send(1'b1, 8'h55, 1'b0);
    send(1'b1, 8'hD5, 1'b0);
    send(1'b1, 8'hAA, 1'b0);
    send(1'b1, 8'h55, 1'b0);
    reset = 1'b0;
    #1;
    chk("midrst_out0", {1'b0, f0, l0, v0, fe0, ce0, pe0, sh0, d0, len0}, 32'd0);
    chk("midrst_out1", {1'b0, f1, l1, v1, fe1, ce1, pe1, sh1, d1, len1}, 32'd0);
    send(1'b1, 8'hD5, 1'b0);
    send(1'b1, 8'h55, 1'b0);
    send(1'b1, 8'h55, 1'b0);
    reset = 1'b1;
    send(1'b1, 8'h55, 1'b0);
    send(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < 6; i++) send(1'b1, 8'h31 + 8'(i), 1'b0);
    send(1'b0, 8'h00, 1'b0);
    frame(7, good, -1);

    for (int k = 0; k < 40; k++) begin
      len = int'($urandom_range(24));
      nb  = rand_bytes_q(len, body);
      if ($urandom_range(1) == 1) begin
        fcs = ~crc_bytes(body);
        for (int j = 0; j < 4; j++) body.push_back(fcs[8*j +: 8]);
      end
      er_idx = -1;
      if ($urandom_range(7) == 0 && body.size() > 0) begin
        er_idx = int'($urandom_range(body.size() - 1));
      end
      frame(int'($urandom_range(1, 7)), body, er_idx);
    end

    repeat (20) send(1'b0, 8'h00, 1'b0);
    chk("beats0_left", bq0.size(), 32'd0);
    chk("beats1_left", bq1.size(), 32'd0);
    chk("stats0_left", sq0.size(), 32'd0);
    chk("stats1_left", sq1.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
